fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares one 16x8 FIFO write port between NREQ producers. Each producer offers bytes on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, drives the FIFO `we`/`data_in` pair, and back-pressures on the FIFO `full` flag. It sits directly in front of the `fifo` instance and owns its write side exclusively.

## Interface
- `NREQ`, 4 — number of requesters, 2..8.
- `DW`, 8 — data width; must match the FIFO word width.
- `BURST_LEN`, 4 — maximum accepted beats per grant, 1..15.
- `IW`, `$clog2(NREQ)` — derived; width of `grant_id` and `stat_sel`.

Ports (`name direction width meaning`):
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `req_valid` in NREQ — requester i has a byte on its data lane.
- `req_data` in NREQ*DW — lane i is bits [i*DW +: DW].
- `req_ready` out NREQ — arbiter accepts lane i this cycle.
- `fifo_we` out 1 — to FIFO `we`.
- `fifo_data` out DW — to FIFO `data_in`.
- `fifo_full` in 1 — from FIFO `full`.
- `grant_id` out IW — current burst owner; valid only while `busy`=1.
- `busy` out 1 — high in the BURST state.
- `stat_sel` in IW — selects the requester whose counter appears on `stat_count`.
- `stat_clr` in 1 — clears all statistics counters.
- `stat_count` out 16 — accepted-beat count for requester `stat_sel`.

## Operation
- Two states:
  - IDLE: no owner.
  - BURST: an owner is held; register `owner` drives `grant_id`.
- Registers: `state`, `owner`, `rr_ptr` (IW bits), `beat_cnt` (4 bits).
- Arbitration picks the first i with `req_valid[i]`=1, scanning from `rr_ptr` upward modulo NREQ.
- IDLE behaviour:
  - If any `req_valid` is high, go to BURST with `owner` = the arbitration winner and `beat_cnt`=0.
  - Otherwise stay in IDLE.
- `req_ready[i]` = (state==BURST) && (owner==i) && !`fifo_full`. It is combinational, and only one bit can be high.
- A beat transfers when `req_valid[owner]` && `req_ready[owner]`. On a beat:
  - `fifo_we`=1 and `fifo_data`=lane `owner`.
  - `beat_cnt` increments.
- When no beat transfers, `fifo_we`=0 and `fifo_data`=0.
- The burst ends in BURST when either condition holds:
  - (a) `req_valid[owner]`=0, or
  - (b) a beat transfers with `beat_cnt`==BURST_LEN-1.
- At burst end:
  - `rr_ptr` = (owner+1) mod NREQ, with wrap.
  - Arbitration runs in the same cycle with start point (owner+1) mod NREQ. A winner gives BURST with a new owner and `beat_cnt`=0; no winner gives IDLE.
  - The previous owner can win again only if it is the sole valid requester.
- `fifo_full`=1 during BURST:
  - No beat; `beat_cnt` and `owner` hold.
  - Ending by (a) is still evaluated.
- `req_valid` is level-sensitive. A requester must hold `req_data` stable while `req_valid`=1 and `req_ready`=0.

## Timing
- Reset (synchronous) forces:
  - `state`=IDLE, `owner`=0, `rr_ptr`=0, `beat_cnt`=0.
  - On outputs: `req_ready`=0, `fifo_we`=0, `fifo_data`=0, `grant_id`=0, `busy`=0.
  - Statistics counters cleared; `stat_count`=0.
- Reset mid-burst abandons the burst. A beat presented in the reset cycle is not written.
- Latency: `req_valid` rising in IDLE gives `req_ready` high on the next cycle, if not full.
- Back-to-back bursts between different owners have zero idle cycles.
- Sustained throughput is 1 beat/cycle while not full.
- `fifo_full` reaches `req_ready` combinationally in the same cycle, so no write is ever issued while full.

## Configuration
- Macro `FIFO_ARB_STATS_EN`.
- Defined:
  - One 16-bit counter per requester increments on each accepted beat of that requester.
  - Counters saturate at 0xFFFF.
  - `stat_clr`=1 zeroes all counters; it takes priority over an increment in the same cycle.
  - `stat_count` is a combinational mux on `stat_sel`.
- Undefined:
  - No counter logic.
  - `stat_count` is tied to 0; `stat_sel` and `stat_clr` are ignored.
  - The ports remain, so the port list is identical in both builds.

## Test plan
- Single requester: `req_valid`=4'b0001, lane0=0xA5, BURST_LEN=4.
  - `busy`=1 one cycle after valid.
  - 4 writes of 0xA5, then the burst ends and requester 0 is re-granted with no gap.
  - `grant_id`=0 throughout.
- All four valid continuously.
  - Grants rotate 0,1,2,3,0, each burst exactly 4 `fifo_we` pulses.
  - No idle cycle between bursts.
- Back-pressure: hold `fifo_full`=1 for 3 cycles mid-burst, after beat 2.
  - `req_ready`=0 and `fifo_we`=0 for those 3 cycles.
  - `beat_cnt` holds; beats 3 and 4 follow when `fifo_full`=0.
- Early release: requester 2 drops `req_valid` after 2 beats while requester 3 is valid.
  - `grant_id` moves to 3 on the next cycle with no bubble.
  - `rr_ptr`=3.
- Reset mid-burst: assert `reset` during requester 1's beat 2.
  - Next cycle all outputs are 0 and `state` is IDLE.
  - Re-arbitration starts from `rr_ptr`=0.
- With `FIFO_ARB_STATS_EN`: 4 beats from requester 2, then `stat_sel`=2.
  - `stat_count`=4.
  - `stat_clr` pulse gives `stat_count`=0.
  - Without the macro, `stat_count`=0 always.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port between NREQ
//   valid/ready producers. One producer owns the port for a burst of at
//   most BURST_LEN accepted beats; the FIFO full flag back-pressures the
//   owner combinationally, so no write is ever issued while full.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake, one bit per lane
//   req_data            : lane i occupies bits [i*DW +: DW]
//   fifo_we/fifo_data   : FIFO write side (data is zero when no write)
//   fifo_full           : FIFO full flag
//   grant_id/busy       : current burst owner, meaningful while busy=1
//   stat_sel/stat_clr   : statistics select / clear-all
//   stat_count          : accepted-beat count of requester stat_sel
//
// Build option
//   FIFO_ARB_STATS_EN : when defined, per-requester saturating 16-bit
//   accepted-beat counters are built; otherwise stat_count is tied to 0
//   and stat_sel/stat_clr are ignored (port list is identical).

module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int IW        = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_data,
    input  logic               fifo_full,
    output logic [IW-1:0]      grant_id,
    output logic               busy,
    input  logic [IW-1:0]      stat_sel,
    input  logic               stat_clr,
    output logic [15:0]        stat_count
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam logic [3:0]    LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NREQ - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;

    logic [DW-1:0] lane [NREQ];
    logic          beat;
    logic          burst_end;
    logic          arb_found;
    logic [IW-1:0] arb_start;
    logic [IW-1:0] arb_winner;
    logic [IW-1:0] owner_next;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane[g] = req_data[g*DW +: DW];
    end

    assign owner_next = (owner_q == LAST_REQ) ? '0 : owner_q + IW'(1);

    // At a burst end the scan starts just past the current owner, so the
    // owner is considered last and only wins again when alone.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        arb_start  = (state_q == BURST) ? owner_next : rr_ptr_q;
        arb_found  = 1'b0;
        arb_winner = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(arb_start) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!arb_found && req_valid[idx[IW-1:0]]) begin
                arb_found  = 1'b1;
                arb_winner = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        fifo_we    = 1'b0;
        fifo_data  = '0;
        beat       = 1'b0;
        burst_end  = 1'b0;

        // Handshake is suppressed in the reset cycle so an offered beat is dropped.
        if (state_q == BURST && !reset) begin
            req_ready[owner_q] = !fifo_full;
            beat               = req_valid[owner_q] && !fifo_full;
        end

        if (beat) begin
            fifo_we    = 1'b1;
            fifo_data  = lane[owner_q];
            beat_cnt_d = beat_cnt_q + 4'd1;
        end

        burst_end = (state_q == BURST) &&
                    (!req_valid[owner_q] || (beat && beat_cnt_q == LAST_BEAT));

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = BURST;
                    owner_d    = arb_winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (burst_end) begin
                    rr_ptr_d = owner_next;
                    if (arb_found) begin
                        owner_d    = arb_winner;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_cnt [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        logic [15:0] cnt_q, cnt_d;

        // Clear wins over a same-cycle increment; counters stick at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (stat_clr) begin
                cnt_d = '0;
            end else if (beat && owner_q == IW'(g) && cnt_q != '1) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stat_cnt[g] = cnt_q;
    end

    assign stat_count = (32'(stat_sel) < NREQ) ? stat_cnt[stat_sel] : '0;
`else
    logic unused_stat;

    assign unused_stat = ^{stat_sel, stat_clr};
    assign stat_count  = '0;
`endif

endmodule
